demux1to4_32b_reg: RTL and testbench
====================================

# demux1to4_32b_reg

Registered 1-to-4 demultiplexer for `INTERNAL_BITS`-wide datapath words. It is the distribution counterpart of the 4-to-1 datapath mux. A single valid/ready input stream carries a 2-bit destination select. Each accepted word is steered into one of four independent one-entry output slots, and each slot drains through its own valid/ready port. It sits where one producer (e.g. ALU result bus) must feed four consumers that can stall independently.

## Interface
- DATA_W, default `INTERNAL_BITS` (32), word width
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  word accepted this cycle when in_valid && in_ready
- in_data  in  DATA_W  word to route
- in_sel  in  2  destination slot 0..3; must be stable with in_data while in_valid is high
- out_valid  out  4  bit k: slot k holds a word
- out_ready  in  4  bit k: consumer k takes slot k's word this cycle
- out_data0..out_data3  out  DATA_W each  slot k contents
- busy  out  1  OR of out_valid

## Operation
- Slot k state: full_k (1 bit), data_k (DATA_W). out_valid[k] = full_k, out_data_k = data_k.
- Input accept condition: in_valid && in_ready.
- in_ready = !full[in_sel] || out_ready[in_sel]. This is combinational from in_sel, the full bits and out_ready. It is evaluated even when in_valid=0.
- Per slot k, per cycle:
  - load_k = accept && (in_sel==k)
  - drain_k = full_k && out_ready[k]
  - load_k: data_k <= in_data, full_k <= 1. Covers the simultaneous drain-and-reload case: the old word leaves and the new word is held, with no bubble.
  - drain_k only: full_k <= 0; data_k holds its last value.
  - neither: no change.
- Slots are independent. A stalled slot blocks only inputs addressed to it, never the other three.
- No reordering within a slot. Words to different slots carry no ordering guarantee.
- No words are dropped or duplicated. A word leaves the block only via an out_valid && out_ready handshake.

## Timing
- Reset (rst_n=0, asynchronous): full_k=0, data_k=0 for all k. Outputs at reset: out_valid=4'b0000, out_data0..3=0, busy=0. in_ready=1, since all slots are empty.
- Reset mid-operation discards all held words immediately. The first accept is possible in the first cycle with rst_n=1.
- Latency: a word accepted at edge N is visible on out_valid/out_data_k after edge N, so it is consumable in cycle N+1.
- Throughput: 1 word/cycle sustained to a single slot whose consumer holds out_ready=1. Up to 4 slots can drain in the same cycle.
- Stall stability: while out_valid[k]=1 and out_ready[k]=0, out_data_k is held constant.
- out_ready[k] while out_valid[k]=0 has no effect.
- in_sel changing while in_valid=0 is legal. in_ready follows it in the same cycle.

## Structure
- `INTERNAL_BITS` comes from the shared def.v. No new global constants; the slot count of 4 is fixed by the 2-bit in_sel.
- One sub-module, out_slot: a one-entry valid/ready register.
  - Inputs: clk, rst_n, load, in_data, out_ready.
  - Outputs: full, data.
  - Instantiated 4 times.
- The top level contains only the sel decode, the in_ready mux and the busy OR.

## Test plan
- Reset then idle: rst_n low 3 cycles -> out_valid=0000, out_data*=0, busy=0, in_ready=1. Assert rst_n low mid-cycle -> outputs clear before the next edge.
- Single route: in_data=32'hDEADBEEF, in_sel=2, out_ready=0 -> next cycle out_valid=0100, out_data2=DEADBEEF. It holds for 5 stalled cycles. Raise out_ready[2] -> out_valid=0000 after the edge.
- Back-pressure isolation: slot 1 full with out_ready[1]=0. in_sel=1 -> in_ready=0 and nothing accepted. Switch in_sel=3 -> in_ready=1, word lands in slot 3 only, and slot 1 keeps its data.
- Same-cycle drain+reload: slot 0 holds 32'h1, out_ready[0]=1, in_valid=1, in_sel=0, in_data=32'h2 -> after the edge out_valid[0]=1, out_data0=2, and exactly one handshake on port 0.
- Streaming: 100 words with incrementing data and sel = i mod 4; random out_ready patterns -> scoreboard checks per-slot order, no loss or duplication, and each word appears exactly once on the port matching its sel.
- Reset mid-stream: all 4 slots full, pulse rst_n low -> out_valid=0000, held words discarded. The next accepted word appears normally one cycle later.

Source files
------------

// File: rtl/demux1to4_32b_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-4 datapath demultiplexer.
package demux1to4_32b_reg_pkg;

  localparam int unsigned INTERNAL_BITS = 32;
  localparam int unsigned NUM_SLOTS     = 4;
  localparam int unsigned SEL_W         = 2;

  // One-hot destination vector for a slot select.
  function automatic logic [NUM_SLOTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_SLOTS'(1) << sel;
  endfunction

endpackage

// File: rtl/demux1to4_32b_reg_out_slot.sv
// One-entry valid/ready holding register; a load in the same cycle as a drain
// replaces the outgoing word with no bubble.
module out_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= in_data;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_32b_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into one of four
// independently draining one-entry output slots.
module demux1to4_32b_reg
  import demux1to4_32b_reg_pkg::*;
#(
  parameter int unsigned DATA_W = INTERNAL_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [SEL_W-1:0]     in_sel,
  output logic [NUM_SLOTS-1:0] out_valid,
  input  logic [NUM_SLOTS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data0,
  output logic [DATA_W-1:0]    out_data1,
  output logic [DATA_W-1:0]    out_data2,
  output logic [DATA_W-1:0]    out_data3,
  output logic                 busy
);

  logic [NUM_SLOTS-1:0] slot_full;
  logic [NUM_SLOTS-1:0] slot_load;
  logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
  logic                 accept;

  // Only the addressed slot can stall the producer.
  assign in_ready  = !slot_full[in_sel] || out_ready[in_sel];
  assign accept    = in_valid && in_ready;
  assign slot_load = accept ? sel_onehot(in_sel) : '0;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .full      (slot_full[k]),
      .data      (slot_data[k])
    );
  end

  assign out_valid = slot_full;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign busy      = |slot_full;

endmodule

// File: tb/tb_demux1to4_32b_reg.sv
// Directed bench for demux1to4_32b_reg with a per-slot scoreboard for streaming.
module tb_demux1to4_32b_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  demux1to4_32b_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_data(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  logic [31:0] sb [4][$];

  initial begin
    int sent;
    int drained;
    logic [31:0] exp_word;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;

    // Reset and idle
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_data0", 64'(out_data0), 64'h0);
    check("rst_data3", 64'(out_data3), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;

    // Single route to slot 2 with a stalled consumer
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    #1;
    check("route_in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("route_valid", 64'(out_valid), 64'h4);
    check("route_data2", 64'(out_data2), 64'hDEADBEEF);
    check("route_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 64'(out_valid), 64'h4);
      check("stall_data2", 64'(out_data2), 64'hDEADBEEF);
    end
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    check("drain2_valid", 64'(out_valid), 64'h0);
    check("drain2_data_hold", 64'(out_data2), 64'hDEADBEEF);

    // Back-pressure isolation between slot 1 and slot 3
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1111_0001;
    step();
    in_data = 32'hBAD0_0001;
    #1;
    check("bp_in_ready_sel1", 64'(in_ready), 64'h0);
    step();
    check("bp_no_accept_valid", 64'(out_valid), 64'h2);
    check("bp_no_accept_data1", 64'(out_data1), 64'h1111_0001);
    in_sel = 2'd3; in_data = 32'h3333_0003;
    #1;
    check("bp_in_ready_sel3", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("bp_valid", 64'(out_valid), 64'hA);
    check("bp_data3", 64'(out_data3), 64'h3333_0003);
    check("bp_data1_hold", 64'(out_data1), 64'h1111_0001);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check("bp_drain_valid", 64'(out_valid), 64'h0);

    // Simultaneous drain and reload on slot 0
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h1;
    step();
    in_data = 32'h2; out_ready = 4'b0001;
    #1;
    check("dr_in_ready", 64'(in_ready), 64'h1);
    check("dr_old_word", 64'(out_data0), 64'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    check("dr_valid", 64'(out_valid), 64'h1);
    check("dr_data0", 64'(out_data0), 64'h2);
    step();
    check("dr_no_extra_drain", 64'(out_valid), 64'h1);
    out_ready = 4'b0001;
    step();
    out_ready = 4'b0000;
    check("dr_final_drain", 64'(out_valid), 64'h0);

    // Fill all slots then assert reset mid-cycle
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 32'hF000_0000 + 32'(k);
      step();
    end
    in_valid = 1'b0;
    check("full_valid", 64'(out_valid), 64'hF);
    check("full_data3", 64'(out_data3), 64'hF000_0003);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_data2", 64'(out_data2), 64'h0);
    check("async_rst_busy", 64'(busy), 64'h0);
    check("async_rst_in_ready", 64'(in_ready), 64'h1);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h0000_0005;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'h2);
    check("post_rst_data1", 64'(out_data1), 64'h5);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check("post_rst_drain", 64'(out_valid), 64'h0);

    // Streaming with random back-pressure
    sent = 0;
    drained = 0;
    for (int cyc = 0; cyc < 3000 && drained < 100; cyc++) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_data   = 32'hA500_0000 + 32'(sent);
      in_sel    = 2'(sent);
      out_ready = 4'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          check("stream_drain_expected", 64'(sb[k].size() != 0), 64'h1);
          if (sb[k].size() != 0) begin
            exp_word = sb[k].pop_front();
            check("stream_data", 64'(get_data(k)), 64'(exp_word));
          end
          drained++;
        end
      end
      if (in_valid && in_ready) begin
        sb[in_sel].push_back(in_data);
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    check("stream_sent", 64'(sent), 64'd100);
    check("stream_drained", 64'(drained), 64'd100);
    check("stream_idle_busy", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
